pipe_reg_de_skid: RTL and testbench

PIPE_REG_DE_SKID -- requirements
Module: pipe_reg_de_skid

---
 rtl/pipe_reg_de_skid_pkg.sv | 44 ++++
 rtl/pipe_reg_de_skid_sat_counter.sv | 23 ++
 rtl/pipe_reg_de_skid.sv | 146 ++++++++++++++
 tb/tb_pipe_reg_de_skid.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_de_skid_pkg.sv
// Shared definitions for the decode/execute skid pipeline register:
// control-bundle field offsets and the occupancy state encoding.
package pipe_reg_de_skid_pkg;

    localparam int CTRL_ALUSRC_LSB     = 0;
    localparam int CTRL_ALUSRC_W       = 2;
    localparam int CTRL_ALUCONTROL_LSB = 2;
    localparam int CTRL_ALUCONTROL_W   = 3;
    localparam int CTRL_BRANCH_BIT     = 5;
    localparam int CTRL_JUMP_BIT       = 6;
    localparam int CTRL_MEMWRITE_BIT   = 7;
    localparam int CTRL_RESULTSRC_LSB  = 8;
    localparam int CTRL_RESULTSRC_W    = 2;
    localparam int CTRL_REGWRITE_BIT   = 10;
    localparam int CTRL_PACKED_W       = 11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    function automatic logic [CTRL_PACKED_W-1:0] pack_ctrl(
        input logic       regwrite,
        input logic [1:0] resultsrc,
        input logic       memwrite,
        input logic       jump,
        input logic       branch,
        input logic [2:0] alucontrol,
        input logic [1:0] alusrc
    );
        logic [CTRL_PACKED_W-1:0] v;
        v = '0;
        v[CTRL_REGWRITE_BIT] = regwrite;
        v[CTRL_RESULTSRC_LSB +: CTRL_RESULTSRC_W] = resultsrc;
        v[CTRL_MEMWRITE_BIT] = memwrite;
        v[CTRL_JUMP_BIT] = jump;
        v[CTRL_BRANCH_BIT] = branch;
        v[CTRL_ALUCONTROL_LSB +: CTRL_ALUCONTROL_W] = alucontrol;
        v[CTRL_ALUSRC_LSB +: CTRL_ALUSRC_W] = alusrc;
        return v;
    endfunction

endpackage

// File: rtl/pipe_reg_de_skid_sat_counter.sv
// Saturating up-counter: steps by one on inc and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_reg_de_skid.sv
// Decode-to-execute pipeline register with a one-entry skid buffer, so that
// ready_d is purely registered while still sustaining one entry per cycle.
module pipe_reg_de_skid
    import pipe_reg_de_skid_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 11,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_de,
    input  logic              valid_d,
    output logic              ready_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    input  logic [REG_W-1:0]  rd_d,
    input  logic [REG_W-1:0]  rs1_d,
    input  logic [REG_W-1:0]  rs2_d,
    output logic              valid_e,
    input  logic              ready_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [DATA_W-1:0] data_e,
    output logic [REG_W-1:0]  rd_e,
    output logic [REG_W-1:0]  rs1_e,
    output logic [REG_W-1:0]  rs2_e,
    output logic [CNT_W-1:0]  flush_cnt
);

    skid_state_e       r_state;
    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [REG_W-1:0]  r_main_rd;
    logic [REG_W-1:0]  r_main_rs1;
    logic [REG_W-1:0]  r_main_rs2;
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [REG_W-1:0]  r_skid_rd;
    logic [REG_W-1:0]  r_skid_rs1;
    logic [REG_W-1:0]  r_skid_rs2;

    logic w_in_fire;
    logic w_out_fire;
    logic w_flush_inc;

    assign ready_d     = ~r_skid_valid;
    assign w_in_fire   = valid_d & ready_d;
    assign w_out_fire  = r_main_valid & ready_e;
    assign w_flush_inc = clr_de & (r_state != ST_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_main_rd    <= '0;
            r_main_rs1   <= '0;
            r_main_rs2   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
            r_skid_rd    <= '0;
            r_skid_rs1   <= '0;
            r_skid_rs2   <= '0;
        end else if (clr_de) begin
            // Flush wins over everything; main data/indices stay for debug visibility.
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state      <= ST_ONE;
                        r_main_valid <= 1'b1;
                        r_main_ctrl  <= ctrl_d;
                        r_main_data  <= data_d;
                        r_main_rd    <= rd_d;
                        r_main_rs1   <= rs1_d;
                        r_main_rs2   <= rs2_d;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_ctrl <= ctrl_d;
                        r_main_data <= data_d;
                        r_main_rd   <= rd_d;
                        r_main_rs1  <= rs1_d;
                        r_main_rs2  <= rs2_d;
                    end else if (w_in_fire) begin
                        r_state      <= ST_FULL;
                        r_skid_valid <= 1'b1;
                        r_skid_ctrl  <= ctrl_d;
                        r_skid_data  <= data_d;
                        r_skid_rd    <= rd_d;
                        r_skid_rs1   <= rs1_d;
                        r_skid_rs2   <= rs2_d;
                    end else if (w_out_fire) begin
                        r_state      <= ST_EMPTY;
                        r_main_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_state      <= ST_ONE;
                        r_skid_valid <= 1'b0;
                        r_main_ctrl  <= r_skid_ctrl;
                        r_main_data  <= r_skid_data;
                        r_main_rd    <= r_skid_rd;
                        r_main_rs1   <= r_skid_rs1;
                        r_main_rs2   <= r_skid_rs2;
                    end
                end
                default: begin
                    r_state      <= ST_EMPTY;
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end
            endcase
        end
    end

    // A bubble must never carry live write/branch controls into execute.
    assign valid_e = r_main_valid;
    assign ctrl_e  = r_main_valid ? r_main_ctrl : '0;
    assign data_e  = r_main_data;
    assign rd_e    = r_main_rd;
    assign rs1_e   = r_main_rs1;
    assign rs2_e   = r_main_rs2;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (w_flush_inc),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_pipe_reg_de_skid.sv
// Bench for pipe_reg_de_skid: directed scenarios plus random traffic, all
// compared against a FIFO-style reference model of at most two entries.
module tb_pipe_reg_de_skid;
    import pipe_reg_de_skid_pkg::*;

    typedef struct packed {
        logic [10:0]  ctrl;
        logic [159:0] data;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
    } entry_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr_de;
    logic         valid_d;
    logic         ready_e;
    logic [10:0]  ctrl_d;
    logic [159:0] data_d;
    logic [4:0]   rd_d, rs1_d, rs2_d;

    logic         ready_d, valid_e;
    logic [10:0]  ctrl_e;
    logic [159:0] data_e;
    logic [4:0]   rd_e, rs1_e, rs2_e;
    logic [15:0]  flush_cnt;

    logic         s_ready_d, s_valid_e;
    logic [10:0]  s_ctrl_e;
    logic [159:0] s_data_e;
    logic [4:0]   s_rd_e, s_rs1_e, s_rs2_e;
    logic [1:0]   s_flush_cnt;

    int total = 0;
    int bad = 0;

    entry_t      q[$];
    entry_t      held;
    int unsigned mCnt;
    int unsigned mCnt2;

    always #5 clk = ~clk;

    pipe_reg_de_skid dut (
        .clk(clk), .rst_n(rst_n), .clr_de(clr_de),
        .valid_d(valid_d), .ready_d(ready_d),
        .ctrl_d(ctrl_d), .data_d(data_d), .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .valid_e(valid_e), .ready_e(ready_e),
        .ctrl_e(ctrl_e), .data_e(data_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .flush_cnt(flush_cnt)
    );

    pipe_reg_de_skid #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr_de(clr_de),
        .valid_d(valid_d), .ready_d(s_ready_d),
        .ctrl_d(ctrl_d), .data_d(data_d), .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .valid_e(s_valid_e), .ready_e(ready_e),
        .ctrl_e(s_ctrl_e), .data_e(s_data_e), .rd_e(s_rd_e), .rs1_e(s_rs1_e), .rs2_e(s_rs2_e),
        .flush_cnt(s_flush_cnt)
    );

    function automatic entry_t randEntry(input logic [4:0] rd);
        entry_t e;
        e.ctrl = pack_ctrl(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                           1'($urandom), 3'($urandom), 2'($urandom));
        e.data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        e.rd   = rd;
        e.rs1  = 5'($urandom);
        e.rs2  = 5'($urandom);
        return e;
    endfunction

    task automatic modelReset();
        q.delete();
        held  = '0;
        mCnt  = 0;
        mCnt2 = 0;
    endtask

    // One clock edge of the reference: a flush empties the queue, otherwise
    // pop the head if execute took it, then append the new entry if there was room.
    task automatic modelStep(input bit v, input bit r, input bit c, input entry_t e);
        bit outF, inF;
        if (c) begin
            if (q.size() > 0) begin
                if (mCnt < 65535) mCnt++;
                if (mCnt2 < 3) mCnt2++;
            end
            q.delete();
        end else begin
            outF = (q.size() > 0) && r;
            inF  = v && (q.size() < 2);
            if (outF) void'(q.pop_front());
            if (inF) q.push_back(e);
        end
        if (q.size() > 0) held = q[0];
    endtask

    task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string ph);
        bit hasMain;
        hasMain = (q.size() > 0);
        checkOutput({ph, ":ready_d"}, 160'(ready_d), 160'(q.size() < 2));
        checkOutput({ph, ":valid_e"}, 160'(valid_e), 160'(hasMain));
        checkOutput({ph, ":ctrl_e"}, 160'(ctrl_e), hasMain ? 160'(q[0].ctrl) : 160'(0));
        checkOutput({ph, ":data_e"}, data_e, held.data);
        checkOutput({ph, ":rd_e"}, 160'(rd_e), 160'(held.rd));
        checkOutput({ph, ":rs1_e"}, 160'(rs1_e), 160'(held.rs1));
        checkOutput({ph, ":rs2_e"}, 160'(rs2_e), 160'(held.rs2));
        checkOutput({ph, ":flush_cnt"}, 160'(flush_cnt), 160'(mCnt));
        checkOutput({ph, ":sat_flush_cnt"}, 160'(s_flush_cnt), 160'(mCnt2));
        checkOutput({ph, ":sat_valid_e"}, 160'(s_valid_e), 160'(hasMain));
    endtask

    task automatic applyStimulus(input bit v, input bit r, input bit c, input entry_t e, input string ph);
        valid_d = v;
        ready_e = r;
        clr_de  = c;
        ctrl_d  = e.ctrl;
        data_d  = e.data;
        rd_d    = e.rd;
        rs1_d   = e.rs1;
        rs2_d   = e.rs2;
        checkAll(ph);
        @(posedge clk);
        modelStep(v, r, c, e);
        #1;
    endtask

    initial begin
        entry_t nul;
        nul = '0;
        rst_n = 1'b0;
        clr_de = 1'b0; valid_d = 1'b0; ready_e = 1'b0;
        ctrl_d = '0; data_d = '0; rd_d = '0; rs1_d = '0; rs2_d = '0;
        modelReset();
        #3;
        checkAll("reset");
        #9 rst_n = 1'b1;

        // Back-to-back stream with execute always ready.
        applyStimulus(1, 1, 0, randEntry(5'h09), "stream0");
        checkOutput("stream_valid0", 160'(valid_e), 160'(1));
        checkOutput("stream_rd0", 160'(rd_e), 160'(5'h09));
        applyStimulus(1, 1, 0, randEntry(5'h0D), "stream1");
        checkOutput("stream_rd1", 160'(rd_e), 160'(5'h0D));
        applyStimulus(1, 1, 0, randEntry(5'h19), "stream2");
        checkOutput("stream_rd2", 160'(rd_e), 160'(5'h19));
        checkOutput("stream_ready", 160'(ready_d), 160'(1));
        applyStimulus(0, 1, 0, nul, "drain");

        // Stall fills the skid, release drains it in order.
        applyStimulus(1, 0, 0, randEntry(5'h01), "stallA");
        applyStimulus(1, 0, 0, randEntry(5'h02), "stallB");
        checkOutput("full_ready_d", 160'(ready_d), 160'(0));
        checkOutput("full_rd_head", 160'(rd_e), 160'(5'h01));
        applyStimulus(1, 0, 0, randEntry(5'h1F), "stallRefused");
        applyStimulus(0, 1, 0, nul, "release");
        checkOutput("release_rd", 160'(rd_e), 160'(5'h02));
        checkOutput("release_ready_d", 160'(ready_d), 160'(1));

        // Flush from FULL with a colliding input.
        applyStimulus(1, 0, 0, randEntry(5'h03), "refill");
        applyStimulus(1, 0, 1, randEntry(5'h04), "flushFull");
        checkOutput("flush_valid_e", 160'(valid_e), 160'(0));
        checkOutput("flush_ctrl_e", 160'(ctrl_e), 160'(0));
        checkOutput("flush_ready_d", 160'(ready_d), 160'(1));
        checkOutput("flush_cnt1", 160'(flush_cnt), 160'(1));
        checkOutput("flush_rd_held", 160'(rd_e), 160'(5'h02));
        applyStimulus(0, 1, 0, nul, "afterFlush");
        checkOutput("flush_dropped", 160'(valid_e), 160'(0));

        // Idle flush must not count.
        applyStimulus(0, 1, 1, nul, "idleFlush");
        checkOutput("idle_flush_cnt", 160'(flush_cnt), 160'(1));

        // Five effective flushes on top of the one already counted.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, randEntry(5'($urandom)), "satLoad");
            applyStimulus(0, 0, 1, nul, "satFlush");
        end
        checkOutput("sat_cnt2", 160'(s_flush_cnt), 160'(3));
        checkOutput("sat_cnt16", 160'(flush_cnt), 160'(6));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0, randEntry(5'($urandom)), "random");
        end

        // Asynchronous reset while holding one entry.
        applyStimulus(0, 0, 1, nul, "preAsync");
        applyStimulus(1, 0, 0, randEntry(5'h15), "asyncLoad");
        checkOutput("async_pre_valid", 160'(valid_e), 160'(1));
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_valid_e", 160'(valid_e), 160'(0));
        checkOutput("async_ctrl_e", 160'(ctrl_e), 160'(0));
        checkOutput("async_data_e", data_e, 160'(0));
        checkOutput("async_rd_e", 160'(rd_e), 160'(0));
        checkOutput("async_flush_cnt", 160'(flush_cnt), 160'(0));
        checkAll("asyncReset");
        #3 rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                          $urandom_range(0, 9) == 0, randEntry(5'($urandom)), "postReset");
        end
        checkAll("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
